// File: rtl/tlul_sram_responder.sv
// TL-UL slave endpoint: decodes Channel A requests against a single address
// window, services them from an internal word-addressed SRAM and returns
// Channel D responses through a small in-order response queue.
module tlul_sram_responder #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned SIZE_WIDTH   = 3,
  parameter int unsigned SRC_WIDTH    = 2,
  parameter int unsigned SINK_WIDTH   = 1,
  parameter int unsigned OPCODE_WIDTH = 3,
  parameter int unsigned PARAM_WIDTH  = 3,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_BASE = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_MASK = 32'hFFFF_F000,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned RSP_DEPTH    = 2
) (
  input  logic                    clk_100,
  input  logic                    reset,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [OPCODE_WIDTH-1:0] a_opcode,
  input  logic [PARAM_WIDTH-1:0]  a_param,
  input  logic [SIZE_WIDTH-1:0]   a_size,
  input  logic [SRC_WIDTH-1:0]    a_source,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [MASK_WIDTH-1:0]   a_mask,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [OPCODE_WIDTH-1:0] d_opcode,
  output logic [PARAM_WIDTH-1:0]  d_param,
  output logic [SIZE_WIDTH-1:0]   d_size,
  output logic [SRC_WIDTH-1:0]    d_source,
  output logic [SINK_WIDTH-1:0]   d_sink,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic                    d_error
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH) + 1;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    A_PUT_FULL = 3'd0,
    A_PUT_PART = 3'd1,
    A_GET      = 3'd4
  } a_op_e;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    D_ACK      = 3'd0,
    D_ACK_DATA = 3'd1
  } d_op_e;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [SIZE_WIDTH-1:0]   size;
    logic [SRC_WIDTH-1:0]    source;
    logic [DATA_WIDTH-1:0]   data;
    logic                    error;
  } rsp_t;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  rsp_t                  rsp_q [RSP_DEPTH];
  logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  accept, pop, dec_err, is_get, is_put;
  logic [IDX_W-1:0]      idx;
  logic [ADDR_WIDTH-1:0] align_mask;
  rsp_t                  rsp_new, head;
  logic                  unused_param;

  assign unused_param = ^a_param;

  // Handshake depends only on registered occupancy; reset blocks acceptance.
  assign a_ready = (count_q != CNT_W'(RSP_DEPTH));
  assign d_valid = (count_q != '0) && !reset;
  assign accept  = a_valid && a_ready && !reset;
  assign pop     = d_valid && d_ready;

  // Request decode and response construction, evaluated at acceptance.
  always_comb begin
    align_mask = (ADDR_WIDTH'(1) << a_size) - ADDR_WIDTH'(1);
    is_get     = (a_opcode == A_GET);
    is_put     = (a_opcode == A_PUT_FULL) || (a_opcode == A_PUT_PART);
    dec_err    = !(((a_address & SLAVE_MASK) == SLAVE_BASE) &&
                   ((a_address & align_mask) == '0) &&
                   (a_size <= SIZE_WIDTH'(2)) &&
                   (is_get || is_put));
    idx        = a_address[IDX_W+1:2];
    rsp_new        = '0;
    rsp_new.opcode = is_get ? D_ACK_DATA : D_ACK;
    rsp_new.size   = a_size;
    rsp_new.source = a_source;
    rsp_new.error  = dec_err;
    rsp_new.data   = (is_get && !dec_err) ? mem_q[idx] : '0;
  end

  // Queue pointer and occupancy next state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (accept) wptr_d = wptr_q + PTR_W'(1);
    if (pop)    rptr_d = rptr_q + PTR_W'(1);
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue control registers.
  always_ff @(posedge clk_100) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Response payload storage; contents are only visible while counted.
  always_ff @(posedge clk_100) begin
    if (accept) rsp_q[wptr_q] <= rsp_new;
  end

  // Byte-masked SRAM write for legal Puts.
  always_ff @(posedge clk_100) begin
    if (accept && is_put && !dec_err) begin
      for (int unsigned b = 0; b < MASK_WIDTH; b++) begin
        if (a_mask[b]) mem_q[idx][8*b +: 8] <= a_data[8*b +: 8];
      end
    end
  end

  // Head of queue drives Channel D; fields read as zero when nothing is valid.
  always_comb begin
    head     = rsp_q[rptr_q];
    d_opcode = d_valid ? head.opcode : '0;
    d_size   = d_valid ? head.size   : '0;
    d_source = d_valid ? head.source : '0;
    d_data   = d_valid ? head.data   : '0;
    d_error  = d_valid ? head.error  : 1'b0;
    d_param  = '0;
    d_sink   = '0;
  end

endmodule

// File: tb/tb_tlul_sram_responder.sv
// Scoreboard bench for tlul_sram_responder: a request-level model predicts
// each Channel D response; a monitor compares responses as they appear.
module tb_tlul_sram_responder;

  localparam int DEPTH = 1024;

  logic        clk_100 = 1'b0;
  logic        reset;
  logic        a_valid, a_ready, d_valid, d_ready, d_error;
  logic [2:0]  a_opcode, a_param, a_size, d_opcode, d_param, d_size;
  logic [1:0]  a_source, d_source;
  logic [0:0]  d_sink;
  logic [31:0] a_address, a_data, d_data;
  logic [3:0]  a_mask;

  typedef struct {
    bit [2:0]  op;
    bit [2:0]  size;
    bit [1:0]  src;
    bit [31:0] data;
    bit        err;
    bit        known;
  } exp_t;

  exp_t      sb[$];
  bit [31:0] mdl_mem [DEPTH];
  bit [3:0]  mdl_kn  [DEPTH];
  int        checks = 0;
  int        errors = 0;
  bit        rnd_ready = 0;

  tlul_sram_responder dut (
    .clk_100(clk_100), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_data(d_data),
    .d_error(d_error)
  );

  always #5 clk_100 = ~clk_100;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Request-level reference: decode rules and byte-lane memory.
  function automatic void model_push(bit [2:0] op, bit [2:0] size, bit [1:0] src,
                                     bit [31:0] addr, bit [3:0] mask, bit [31:0] data);
    exp_t e;
    bit   op_ok = (op == 0) || (op == 1) || (op == 4);
    bit   err   = !(((addr & 32'hFFFF_F000) == 0) && ((addr % (32'd1 << size)) == 0) &&
                    (size <= 2) && op_ok);
    int   idx   = int'((addr >> 2) % DEPTH);
    e.op = (op == 4) ? 3'd1 : 3'd0;
    e.size = size; e.src = src; e.err = err; e.data = 0; e.known = 1;
    if (op == 4 && !err) begin
      e.data  = mdl_mem[idx];
      e.known = (mdl_kn[idx] == 4'hF);
    end
    if ((op == 0 || op == 1) && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (mask[b]) begin
          mdl_mem[idx][8*b +: 8] = data[8*b +: 8];
          mdl_kn[idx][b] = 1'b1;
        end
      end
    end
    sb.push_back(e);
  endfunction

  // Monitor: compares every presented response against the scoreboard head.
  always @(negedge clk_100) begin
    if (reset) begin
      chk("rst_d_valid", 32'(d_valid), 0);
      chk("rst_d_opcode", 32'(d_opcode), 0);
      chk("rst_d_data", d_data, 0);
      chk("rst_d_error", 32'(d_error), 0);
    end else begin
      chk("a_ready", 32'(a_ready), 32'(sb.size() < 2));
      chk("d_valid", 32'(d_valid), 32'(sb.size() != 0));
      if (d_valid && sb.size() != 0) begin
        chk("d_opcode", 32'(d_opcode), 32'(sb[0].op));
        chk("d_size", 32'(d_size), 32'(sb[0].size));
        chk("d_source", 32'(d_source), 32'(sb[0].src));
        chk("d_error", 32'(d_error), 32'(sb[0].err));
        chk("d_param", 32'(d_param), 0);
        chk("d_sink", 32'(d_sink), 0);
        if (sb[0].known) chk("d_data", d_data, sb[0].data);
        if (d_ready) void'(sb.pop_front());
      end
    end
  end

  // Random d_ready while enabled.
  initial begin
    forever begin
      @(posedge clk_100); #1;
      if (rnd_ready) d_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input bit [2:0] op, input bit [2:0] size, input bit [1:0] src,
                      input bit [31:0] addr, input bit [3:0] mask, input bit [31:0] data);
    int n = 0;
    a_valid = 1; a_opcode = op; a_size = size; a_source = src;
    a_address = addr; a_mask = mask; a_data = data; a_param = 3'($urandom);
    @(negedge clk_100); #1;
    while (!a_ready && n < 100) begin
      @(negedge clk_100); #1;
      n++;
    end
    if (!a_ready) chk("accept_timeout", 32'(a_ready), 1);
    else model_push(op, size, src, addr, mask, data);
    @(posedge clk_100); #1;
    a_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk_100);
      n++;
    end
    if (n != 0) #1;
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset = 1; a_valid = 0; d_ready = 1; a_opcode = 0; a_param = 0; a_size = 0;
    a_source = 0; a_address = 0; a_mask = 0; a_data = 0;
    repeat (3) @(posedge clk_100);
    #1 reset = 0;

    // Put then partial Put and readback.
    send(3'd0, 3'd2, 2'd1, 32'h100, 4'hF, 32'hCAFEBABE);
    send(3'd1, 3'd2, 2'd1, 32'h100, 4'h3, 32'h1234_5678);
    send(3'd4, 3'd2, 2'd2, 32'h100, 4'hF, 32'h0);
    // Out of range accesses leave index 0 untouched.
    send(3'd0, 3'd2, 2'd0, 32'h0, 4'hF, 32'h1111_2222);
    send(3'd4, 3'd2, 2'd0, 32'h1000, 4'hF, 32'h0);
    send(3'd0, 3'd2, 2'd0, 32'h2000, 4'hF, 32'hDEADBEEF);
    send(3'd4, 3'd2, 2'd3, 32'h0, 4'hF, 32'h0);
    // Misaligned, bad opcode, oversize.
    send(3'd4, 3'd2, 2'd0, 32'h102, 4'hF, 32'h0);
    send(3'd3, 3'd2, 2'd1, 32'h100, 4'hF, 32'h0);
    send(3'd4, 3'd3, 2'd1, 32'h100, 4'hF, 32'h0);
    send(3'd4, 3'd1, 2'd2, 32'h102, 4'hF, 32'h0);
    drain();

    // Backpressure: two accepted, third waits for a single pop.
    d_ready = 0;
    fork
      begin
        send(3'd4, 3'd2, 2'd1, 32'h100, 4'hF, 32'h0);
        send(3'd4, 3'd2, 2'd2, 32'h0, 4'hF, 32'h0);
        send(3'd4, 3'd2, 2'd3, 32'h100, 4'hF, 32'h0);
      end
    join_none
    repeat (6) @(posedge clk_100);
    #1 chk("bp_a_ready_low", 32'(a_ready), 0);
    d_ready = 1;
    @(posedge clk_100); #1 d_ready = 0;
    repeat (3) @(posedge clk_100);
    #1 d_ready = 1;
    wait fork;
    drain();

    // Reset mid-stream with two responses queued.
    send(3'd0, 3'd2, 2'd0, 32'h1C, 4'hF, 32'h0BAD_F00D);
    drain();
    d_ready = 0;
    send(3'd0, 3'd2, 2'd1, 32'h20, 4'hF, 32'hA5A5_0001);
    send(3'd0, 3'd2, 2'd2, 32'h24, 4'hF, 32'hA5A5_0002);
    reset = 1;
    sb.delete();
    @(posedge clk_100); #1 reset = 0;
    d_ready = 1;
    repeat (3) @(posedge clk_100);
    #1 chk("no_stale_rsp", 32'(d_valid), 0);
    // Request presented during reset must not write.
    reset = 1;
    a_valid = 1; a_opcode = 3'd0; a_size = 3'd2; a_address = 32'h1C;
    a_mask = 4'hF; a_data = 32'hBAD0_BAD0;
    @(posedge clk_100); #1 reset = 0; a_valid = 0;
    send(3'd4, 3'd2, 2'd1, 32'h1C, 4'hF, 32'h0);
    send(3'd4, 3'd2, 2'd2, 32'h20, 4'hF, 32'h0);
    drain();

    // Randomized traffic with random backpressure.
    rnd_ready = 1;
    for (int i = 0; i < 400; i++) begin
      bit [2:0]  op, size;
      bit [31:0] addr;
      int        r = $urandom_range(0, 9);
      if (r < 3)      op = 3'd4;
      else if (r < 5) op = 3'd0;
      else if (r < 8) op = 3'd1;
      else begin
        op = 3'($urandom_range(2, 7));
        if (op == 3'd4) op = 3'd2;
      end
      size = ($urandom_range(0, 4) != 0) ? 3'd2 : 3'($urandom_range(0, 3));
      addr = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 7) != 0) addr = addr & ~((32'd1 << size) - 1);
      if ($urandom_range(0, 15) == 0) addr = addr | 32'($urandom_range(1, 15) << 12);
      send(op, size, 2'($urandom), addr, 4'($urandom), $urandom);
    end
    rnd_ready = 0;
    @(posedge clk_100); #1 d_ready = 1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlul_sram_responder.md
Name: tlul_sram_responder

Overview:
- TL-UL slave-side responder: consumes Channel A requests from the interconnect slave socket and returns Channel D responses.
- Backed by an internal word-addressed SRAM array.
- Is the endpoint behind the single slave socket. Supports Get, PutFullData and PutPartialData.
- Returns AccessAck / AccessAckData through a small registered response queue, with d_error on illegal requests.

Parameters:
- ADDR_WIDTH, 32, Channel A address width
- DATA_WIDTH, 32, data bus width; fixed at 32 for this revision
- MASK_WIDTH, DATA_WIDTH/8, byte-mask width
- SIZE_WIDTH, 3, a_size/d_size width
- SRC_WIDTH, 2, source ID width
- SINK_WIDTH, 1, sink ID width
- OPCODE_WIDTH, 3, opcode width
- PARAM_WIDTH, 3, param width
- SLAVE_BASE, 32'h0000_0000, base address of the decode window
- SLAVE_MASK, 32'hFFFF_F000, window match mask
- DEPTH, 1024, SRAM words (power of 2; DEPTH*4 bytes must be at least the window size)
- RSP_DEPTH, 2, response queue entries (power of 2, at least 2)

Ports:
- clk_100  in  1  block clock
- reset  in  1  synchronous, active-high reset
- a_valid  in  1  request valid
- a_ready  out  1  request accepted when a_valid && a_ready on a rising clk_100 edge
- a_opcode  in  OPCODE_WIDTH  0=PutFullData, 1=PutPartialData, 4=Get
- a_param  in  PARAM_WIDTH  ignored
- a_size  in  SIZE_WIDTH  log2 bytes
- a_source  in  SRC_WIDTH  requester ID
- a_address  in  ADDR_WIDTH  byte address
- a_mask  in  MASK_WIDTH  byte enables
- a_data  in  DATA_WIDTH  write data
- d_valid  out  1  response valid
- d_ready  in  1  response consumed when d_valid && d_ready
- d_opcode  out  OPCODE_WIDTH  0=AccessAck, 1=AccessAckData
- d_param  out  PARAM_WIDTH  always 0
- d_size  out  SIZE_WIDTH  echo of a_size
- d_source  out  SRC_WIDTH  echo of a_source
- d_sink  out  SINK_WIDTH  always 0
- d_data  out  DATA_WIDTH  read data; 0 for AccessAck and for errors
- d_error  out  1  request denied

Behaviour:
- Clocking and reset:
  - All state is on the rising edge of clk_100.
  - While reset is high: the queue is emptied, d_valid=0, and d_opcode/d_param/d_size/d_source/d_sink/d_data/d_error=0.
  - a_ready=1 in the first cycle after reset is released.
  - SRAM contents are not reset.
  - Reset mid-operation discards all queued responses. Any request presented in that cycle is not accepted and causes no write.
- Handshake:
  - a_ready = (count != RSP_DEPTH). It is registered-state based, with no combinational path from d_ready or a_valid.
  - d_valid = (count != 0). d_* fields come from the queue head and stay stable while d_valid && !d_ready.
  - Accepting a request and popping the head in the same cycle leaves count unchanged. When full, a pop frees a slot that is usable the next cycle.
- Latency:
  - A request accepted at edge N produces its response visible after edge N, i.e. d_valid can be high in cycle N+1 at the earliest.
  - Responses are returned in acceptance order.
- Decode, evaluated at acceptance:
  - in_range = ((a_address & SLAVE_MASK) == SLAVE_BASE).
  - aligned = (a_address & ((1<<a_size)-1)) == 0.
  - size_ok = (a_size <= 2).
  - op_ok = opcode in {0,1,4}.
  - error = !(in_range && aligned && size_ok && op_ok).
  - index = a_address[$clog2(DEPTH)+1:2].
- Get:
  - Enqueues d_opcode=1 with d_data = SRAM[index] as read at acceptance. A write accepted later does not alter it.
  - On error: d_data=0, d_error=1.
- PutFullData / PutPartialData:
  - When there is no error, byte lane b of SRAM[index] is written with a_data[8b+7:8b] when a_mask[b]=1.
  - Enqueues d_opcode=0, d_data=0.
  - On error: no write, d_error=1.
- Unsupported opcode: enqueues d_opcode=0, d_error=1, no SRAM access.
- Back-to-back: a Get accepted the cycle after a Put to the same index returns the new data (write commits at the Put acceptance edge).
- Queue pointers wrap modulo RSP_DEPTH. count has width $clog2(RSP_DEPTH)+1.

Test Plan:
- Reset, then Put: reset 3 cycles, then PutFullData addr 0x0000_0100, mask 0xF, data 0xCAFEBABE, source 1 → a_ready=1 after reset. Next cycle d_valid=1, d_opcode=0, d_source=1, d_size=2, d_error=0.
- Put/Get readback: PutPartialData addr 0x100, mask 0x3, data 0x1234_5678 after the scenario above, then Get addr 0x100, source 2 → d_opcode=1, d_data=0xCAFE5678, d_source=2.
- Out of range: Get addr 0x0000_1000 (source 0) → d_opcode=1, d_error=1, d_data=0. Then PutFullData 0x0000_2000 → d_error=1, and a later Get of index 0 is unchanged.
- Misaligned / bad opcode: Get addr 0x102 size 2 → d_error=1. Opcode 3 → d_opcode=0, d_error=1.
- Backpressure: d_ready=0, issue 3 Gets → first two accepted, a_ready=0 with count=2. Raise d_ready for 1 cycle → head pops, third request accepted next cycle, order preserved, held d_* stable while stalled.
- Reset mid-stream: 2 responses queued, assert reset 1 cycle → d_valid=0 the cycle after, and no stale response emerges after release.
